// File: rtl/jimmy_pkg.sv
// jimmy_pkg: shared opcodes, default widths and program-memory FSM states for the Jimmy CPU
package jimmy_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam logic [7:0] OP_NOP = 8'b0111_0000;
  typedef enum logic [1:0] {PM_IDLE, PM_LOAD, PM_RUN} pm_state_t;
endpackage

// File: rtl/pm_read_port.sv
// pm_read_port: one core fetch port; NOP while not running, optional 1-cycle output register
//   clk, reset  clock, synchronous active-low reset (clears the output register to NOP)
//   run         memory image valid
//   addr        this core's fetch address
//   mem         whole instruction store, read-only view
//   data        fetched byte (NOP when run=0)
module pm_read_port
  import jimmy_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int READ_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem [2**ADDR_W],
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] nop, rd, data_q;
  assign nop = DATA_W'(OP_NOP);
  assign rd = run ? mem[addr] : nop;
  always_ff @(posedge clk) data_q <= !reset ? nop : rd;
  // the registered copy captured while run=1 is what a core sees in the cycle run falls
  assign data = (READ_REG != 0) ? data_q : rd;
endmodule

// File: rtl/program_memory_mc.sv
// program_memory_mc: runtime-loadable shared instruction store with NUM_CORES fetch ports
//   clk, reset                 clock, synchronous active-low reset (memory contents kept)
//   load_start                 begin (re)loading at address 0 (ignored while loading)
//   load_valid/data/last       byte stream; load_ready high while loading
//   core_addr / core_data      packed per-core fetch address / data, core i at slice i
//   run                        image complete, cores may execute
//   load_count                 bytes stored by the current/last load, saturates at DEPTH
//   overflow                   sticky: image longer than DEPTH, extra bytes dropped
module program_memory_mc
  import jimmy_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int NUM_CORES = 4,
  parameter int READ_REG  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_start,
  input  logic                        load_valid,
  input  logic [DATA_W-1:0]           load_data,
  input  logic                        load_last,
  output logic                        load_ready,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  output logic [NUM_CORES*DATA_W-1:0] core_data,
  output logic                        run,
  output logic [ADDR_W:0]             load_count,
  output logic                        overflow
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  pm_state_t         state;
  logic [ADDR_W-1:0] wptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              full;
  assign full = load_count == DEPTH_C;
  // IDLE and RUN react identically to load_start; only LOAD consumes the byte stream
  always_ff @(posedge clk)
    if (!reset) begin
      state      <= PM_IDLE;
      run        <= 1'b0;
      load_ready <= 1'b0;
      load_count <= '0;
      overflow   <= 1'b0;
      wptr       <= '0;
    end else if (state != PM_LOAD) begin
      if (load_start) begin
        state      <= PM_LOAD;
        run        <= 1'b0;
        load_ready <= 1'b1;
        load_count <= '0;
        overflow   <= 1'b0;
        wptr       <= '0;
      end
    end else if (load_valid) begin
      if (!full) begin
        wptr       <= wptr + 1'b1;
        load_count <= load_count + 1'b1;
      end else overflow <= 1'b1;
      if (load_last) begin
        state      <= PM_RUN;
        run        <= 1'b1;
        load_ready <= 1'b0;
      end
    end
  // no write beyond DEPTH: wptr would wrap and clobber the start of the image
  always_ff @(posedge clk)
    if (reset && load_ready && load_valid && !full) mem[wptr] <= load_data;
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_port
    pm_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_REG(READ_REG)) u_port (
      .clk  (clk),
      .reset(reset),
      .run  (run),
      .addr (core_addr[i*ADDR_W +: ADDR_W]),
      .mem  (mem),
      .data (core_data[i*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_program_memory_mc.sv
// tb_program_memory_mc: randomized check of both read modes against an image-level model
module tb_program_memory_mc;
  localparam int DW = 8, AW = 8, NC = 4, DEPTH = 256;
  logic clk = 0, reset = 0, load_start = 0, load_valid = 0, load_last = 0;
  logic [DW-1:0] load_data = '0;
  logic [NC*AW-1:0] core_addr = '0;
  logic [NC*DW-1:0] data0, data1;
  logic run0, run1, rdy0, rdy1, ovf0, ovf1;
  logic [AW:0] cnt0, cnt1;
  int checks = 0, failures = 0;
  logic [7:0] m_mem [DEPTH];
  bit m_known [DEPTH];
  bit m_loading = 0, m_run = 0, m_ovf = 0;
  int m_count = 0;
  logic [7:0] m_reg [NC];
  bit m_reg_known [NC];
  logic [7:0] bytes [5];
  logic [7:0] first_byte;

  always #5 clk = ~clk;

  program_memory_mc #(.DATA_W(DW), .ADDR_W(AW), .NUM_CORES(NC), .READ_REG(0)) u_comb (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(rdy0), .core_addr(core_addr),
    .core_data(data0), .run(run0), .load_count(cnt0), .overflow(ovf0));
  program_memory_mc #(.DATA_W(DW), .ADDR_W(AW), .NUM_CORES(NC), .READ_REG(1)) u_reg (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(rdy1), .core_addr(core_addr),
    .core_data(data1), .run(run1), .load_count(cnt1), .overflow(ovf1));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic [7:0] nreg [NC];
    bit nk [NC];
    for (int i = 0; i < NC; i++) begin
      int a = int'(core_addr[i*AW +: AW]);
      nreg[i] = (m_run && reset) ? m_mem[a] : 8'h70;
      nk[i] = !(m_run && reset) || m_known[a];
    end
    if (!reset) begin
      m_loading = 0; m_run = 0; m_count = 0; m_ovf = 0;
    end else if (!m_loading) begin
      if (load_start) begin
        m_loading = 1; m_run = 0; m_count = 0; m_ovf = 0;
      end
    end else if (load_valid) begin
      if (m_count < DEPTH) begin
        m_mem[m_count] = load_data;
        m_known[m_count] = 1;
        m_count++;
      end else m_ovf = 1;
      if (load_last) begin
        m_loading = 0; m_run = 1;
      end
    end
    @(posedge clk);
    #1;
    m_reg = nreg;
    m_reg_known = nk;
    check("run", run0, m_run);
    check("run_rr", run1, m_run);
    check("ready", rdy0, m_loading);
    check("ready_rr", rdy1, m_loading);
    check("count", cnt0, m_count);
    check("count_rr", cnt1, m_count);
    check("overflow", ovf0, m_ovf);
    check("overflow_rr", ovf1, m_ovf);
    for (int i = 0; i < NC; i++) begin
      int a = int'(core_addr[i*AW +: AW]);
      if (!m_run) check($sformatf("data%0d_nop", i), data0[i*DW +: DW], 8'h70);
      else if (m_known[a]) check($sformatf("data%0d", i), data0[i*DW +: DW], m_mem[a]);
      if (m_reg_known[i]) check($sformatf("data%0d_rr", i), data1[i*DW +: DW], m_reg[i]);
    end
  endtask

  task automatic send(logic [7:0] d, bit last);
    load_valid = 1; load_data = d; load_last = last;
    tick();
    load_valid = 0; load_last = 0;
  endtask

  task automatic pulse_start();
    load_start = 1;
    tick();
    load_start = 0;
  endtask

  task automatic load_image(int n);
    pulse_start();
    for (int k = 0; k < n; k++) begin
      logic [7:0] d = 8'($urandom);
      if (k == 0) first_byte = d;
      if ($urandom_range(3) == 0) tick();
      if ($urandom_range(7) == 0) core_addr = $urandom;
      send(d, k == n - 1);
    end
  endtask

  initial begin
    tick();
    tick();
    reset = 1;
    // basic 5-byte load
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      bytes[k] = 8'($urandom);
      send(bytes[k], k == 4);
    end
    check("t1_count", cnt0, 5);
    core_addr = {8'd0, 8'd0, 8'd0, 8'd2};
    tick();
    check("t1_byte3", data0[7:0], bytes[2]);
    // all cores at once, registered port lags one cycle
    core_addr = {8'd3, 8'd2, 8'd1, 8'd0};
    tick();
    tick();
    check("t2_rr_core3", data1[31:24], bytes[3]);
    // overflow: 258 bytes into 256 locations
    load_image(258);
    check("t3_count", cnt0, 256);
    check("t3_overflow", ovf0, 1);
    core_addr = '0;
    tick();
    check("t3_mem0", data0[7:0], first_byte);
    tick();
    // reload from RUN, with a coincident valid byte that must be ignored
    load_start = 1; load_valid = 1; load_data = 8'($urandom);
    tick();
    load_start = 0; load_valid = 0;
    check("t4_run_low", run0, 0);
    for (int k = 0; k < 3; k++) send(8'($urandom), k == 2);
    check("t4_count", cnt0, 3);
    check("t4_overflow", ovf0, 0);
    for (int k = 0; k < 4; k++) begin
      core_addr = $urandom;
      tick();
    end
    // reset mid-load, then bytes in IDLE must be ignored
    pulse_start();
    send(8'($urandom), 0);
    send(8'($urandom), 0);
    reset = 0;
    tick();
    reset = 1;
    for (int k = 0; k < 3; k++) send(8'($urandom), k == 2);
    check("t5_count_idle", cnt0, 0);
    load_image(4);
    // random traffic
    for (int k = 0; k < 1500; k++) begin
      reset = $urandom_range(99) != 0;
      load_start = $urandom_range(40) == 0;
      load_valid = $urandom_range(1) == 1;
      load_last = $urandom_range(30) == 0;
      load_data = 8'($urandom);
      core_addr = $urandom;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
